// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller for a 1W1R SRAM macro, with a 2-entry output
// buffer that absorbs the macro's 1-cycle read latency for full throughput.
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1,
    output logic [4:0]            count
);
    logic [ADDR_WIDTH:0]   wr_q, rd_q, occ;
    logic [1:0]            cnt_q, cnt_d, keep;
    logic                  infl_q, push, pop, rd_en;
    logic [DATA_WIDTH-1:0] b0_q, b1_q, b0_d, b1_d;

    // occ never exceeds the depth, so its MSB alone flags a full SRAM
    assign occ        = wr_q - rd_q;
    assign in_ready   = !rst && !occ[ADDR_WIDTH];
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign keep       = cnt_q - {1'b0, pop};
    assign rd_en      = !rst && occ != '0 && ({1'b0, keep} + {2'b0, infl_q}) < 3'd2;
    assign sram_csb0  = !push;
    assign sram_addr0 = wr_q[ADDR_WIDTH-1:0];
    assign sram_din0  = in_data;
    assign sram_csb1  = !rd_en;
    assign sram_addr1 = rd_q[ADDR_WIDTH-1:0];
    assign out_valid  = cnt_q != 2'd0;
    assign out_data   = b0_q;
    assign count      = 5'(occ) + 5'(infl_q) + 5'(cnt_q);

    // returning read data lands at the tail left after this cycle's pop
    always_comb begin
        b0_d  = (infl_q && keep == 2'd0) ? sram_dout1 : pop ? b1_q : b0_q;
        b1_d  = (infl_q && keep != 2'd0) ? sram_dout1 : b1_q;
        cnt_d = keep + {1'b0, infl_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            infl_q <= 1'b0;
        end else begin
            wr_q   <= wr_q + (ADDR_WIDTH+1)'(push);
            rd_q   <= rd_q + (ADDR_WIDTH+1)'(rd_en);
            cnt_q  <= cnt_d;
            infl_q <= rd_en;
        end
        b0_q <= b0_d;
        b1_q <= b1_d;
    end
endmodule
